tekipaki_cen_meter: RTL and testbench

Measures the rate and spacing of one clock-enable strobe produced by the fractional clock-enable generator in the 94.5 MHz domain. Over a fixed window of clock cycles it counts strobes and tracks the minimum and maximum spacing between consecutive strobes. It flags results outside an expected band and hands each window's result to a consumer (debug OSD or testbench) with a VALID/ACK handshake. It sits beside the clock-enable generator and observes its output without modifying it.

---
 rtl/tekipaki_cen_meter.sv | 121 ++++++++++++
 tb/tb_tekipaki_cen_meter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tekipaki_cen_meter.sv
// rtl/tekipaki_cen_meter.sv - windowed rate and spacing meter for one clock-enable strobe
module tekipaki_cen_meter #(
  parameter int WIN    = 94500,
  parameter int CW     = 17,
  parameter int PW     = 8,
  parameter int EXP_LO = 6750,
  parameter int EXP_HI = 6750
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          ENABLE,
  input  logic          CEN,
  input  logic          ACK,
  output logic          VALID,
  output logic          OVERRUN,
  output logic [CW-1:0] COUNT,
  output logic [PW-1:0] PERIOD_MIN,
  output logic [PW-1:0] PERIOD_MAX,
  output logic          STALL,
  output logic          ERR
);

  localparam logic [PW-1:0] IC_MAX   = '1;
  localparam logic [PW-1:0] IC_ONE   = PW'(1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
  localparam logic [CW-1:0] LO       = CW'(EXP_LO);
  localparam logic [CW-1:0] HI       = CW'(EXP_HI);

  typedef enum logic {SYNC, MEASURE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wc, pc, pc_nx;
  logic [PW-1:0] ic, ic_inc, rmin, rmax, min_nx, max_nx;
  logic          rstall, stall_nx;
  logic          win_end, latch;

  always_comb begin
    state_nx = state;
    case (state)
      SYNC:    if (ENABLE && CEN) state_nx = MEASURE;
      MEASURE: if (!ENABLE) state_nx = SYNC;
      default: state_nx = SYNC;
    endcase
  end

  // Running values including this cycle's strobe, so the closing cycle is counted.
  always_comb begin
    ic_inc   = (ic == IC_MAX) ? IC_MAX : ic + 1'b1;
    pc_nx    = pc + {{(CW-1){1'b0}}, CEN};
    min_nx   = (CEN && ic < rmin) ? ic : rmin;
    max_nx   = (CEN && ic > rmax) ? ic : rmax;
    stall_nx = rstall | (!CEN && ic_inc == IC_MAX);
    win_end  = (wc == WIN_LAST);
    latch    = (state == MEASURE) && ENABLE && win_end;
  end

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      state      <= SYNC;
      wc         <= '0;
      pc         <= '0;
      ic         <= '0;
      rmin       <= '0;
      rmax       <= '0;
      rstall     <= 1'b0;
      VALID      <= 1'b0;
      OVERRUN    <= 1'b0;
      COUNT      <= '0;
      PERIOD_MIN <= '1;
      PERIOD_MAX <= '0;
      STALL      <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        SYNC: begin
          if (ENABLE && CEN) begin
            wc     <= '0;
            pc     <= '0;
            ic     <= IC_ONE;
            rmin   <= '1;
            rmax   <= '0;
            rstall <= 1'b0;
          end
        end
        MEASURE: begin
          if (ENABLE) begin
            // ic is never cleared at the boundary: a spacing belongs to its closing strobe's window.
            ic <= CEN ? IC_ONE : ic_inc;
            if (win_end) begin
              COUNT      <= pc_nx;
              PERIOD_MIN <= min_nx;
              PERIOD_MAX <= max_nx;
              STALL      <= stall_nx;
              ERR        <= (pc_nx < LO) || (pc_nx > HI) || stall_nx;
              wc         <= '0;
              pc         <= '0;
              rmin       <= '1;
              rmax       <= '0;
              rstall     <= 1'b0;
            end else begin
              wc     <= wc + 1'b1;
              pc     <= pc_nx;
              rmin   <= min_nx;
              rmax   <= max_nx;
              rstall <= stall_nx;
            end
          end
        end
        default: ;
      endcase
      if (latch) begin
        VALID <= 1'b1;
        if (VALID && !ACK) OVERRUN <= 1'b1;
      end else if (ACK) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tekipaki_cen_meter.sv
// tb/tb_tekipaki_cen_meter.sv - directed bench with timestamp-based scoreboard for tekipaki_cen_meter
module tb_tekipaki_cen_meter;

  localparam int WIN = 700;
  localparam int CW  = 17;
  localparam int PW  = 8;
  localparam int EXP = 100;

  logic          clk = 1'b0;
  logic          resetn, enable, cen, ack;
  logic          valid, overrun, stall, err;
  logic [CW-1:0] count;
  logic [PW-1:0] pmin, pmax;

  tekipaki_cen_meter #(.WIN(WIN), .CW(CW), .PW(PW), .EXP_LO(EXP), .EXP_HI(EXP)) dut (
    .CLK96(clk), .RESET96_N(resetn), .ENABLE(enable), .CEN(cen), .ACK(ack),
    .VALID(valid), .OVERRUN(overrun), .COUNT(count), .PERIOD_MIN(pmin),
    .PERIOD_MAX(pmax), .STALL(stall), .ERR(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int pmin;
    int pmax;
    bit stall;
    bit err;
  } res_t;

  res_t sbq[$];
  int   strobes[$];
  int   total = 0;
  int   passed = 0;
  int   m_cyc = 0;
  int   m_ws = 0;
  bit   m_meas = 0;
  bit   ev = 0;
  bit   eo = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Result of a window built from absolute strobe timestamps; strobes[0] is the reference strobe.
  function automatic res_t close_win(input int ws, input int we);
    res_t r;
    int   a, b, lo, hi, sp;
    r = '{0, 255, 0, 0, 0};
    for (int i = 1; i < strobes.size(); i++) begin
      r.count++;
      sp = strobes[i] - strobes[i-1];
      if (sp > 255) sp = 255;
      if (sp < r.pmin) r.pmin = sp;
      if (sp > r.pmax) r.pmax = sp;
    end
    for (int i = 0; i < strobes.size(); i++) begin
      a  = strobes[i];
      b  = (i + 1 < strobes.size()) ? strobes[i+1] : we + 1;
      lo = (a + 254 > ws) ? a + 254 : ws;
      hi = (b - 1 < we) ? b - 1 : we;
      if (lo <= hi) r.stall = 1;
    end
    r.err = (r.count != EXP) || r.stall;
    return r;
  endfunction

  task automatic step(input logic cen_i, input logic en_i, input logic ack_i, input logic rst_i);
    res_t r;
    bit   latched;
    int   l;
    cen = cen_i; enable = en_i; ack = ack_i; resetn = rst_i;
    @(posedge clk);
    latched = 0;
    if (!rst_i) begin
      m_meas = 0; ev = 0; eo = 0;
      strobes.delete();
    end else begin
      if (!m_meas) begin
        if (en_i && cen_i) begin
          m_meas = 1; m_ws = m_cyc + 1;
          strobes.delete();
          strobes.push_back(m_cyc);
        end
      end else if (!en_i) begin
        m_meas = 0;
      end else begin
        if (cen_i) strobes.push_back(m_cyc);
        if (m_cyc == m_ws + WIN - 1) begin
          sbq.push_back(close_win(m_ws, m_cyc));
          latched = 1;
          m_ws = m_cyc + 1;
          l = strobes[strobes.size()-1];
          strobes.delete();
          strobes.push_back(l);
        end
      end
      if (latched) begin
        if (ev && !ack_i) eo = 1;
        ev = 1;
      end else if (ack_i) begin
        ev = 0;
      end
    end
    m_cyc++;
    #1;
    chk("valid", valid, ev);
    if (latched && sbq.size() > 0) begin
      r = sbq.pop_front();
      chk("count", count, r.count);
      chk("pmin", pmin, r.pmin);
      chk("pmax", pmax, r.pmax);
      chk("stall", stall, r.stall);
      chk("err", err, r.err);
      chk("overrun", overrun, eo);
    end
  endtask

  // Strobes alternate between gaps g0 and g1 counted from the previous strobe; ackm 0 none, 1 when valid, 2 on closing cycle.
  task automatic run(input int n, input int g0, input int g1, input int ackm);
    int  k = 0;
    bit  sel = 0;
    logic c, a;
    for (int i = 0; i < n; i++) begin
      k++;
      c = (k == (sel ? g1 : g0));
      if (c) begin k = 0; sel = ~sel; end
      a = (ackm == 1) ? ev : (ackm == 2) ? (m_meas && m_cyc == m_ws + WIN - 1) : 1'b0;
      step(c, 1'b1, a, 1'b1);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_pmin"}, pmin, 255);
    chk({tag, "_pmax"}, pmax, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int n;
    int k;
    resetn = 1'b0; enable = 1'b0; cen = 1'b0; ack = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_reset("reset");

    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    run(WIN, 7, 7, 1);
    chk("p7_first_count", count, 100);
    chk("p7_first_pmin", pmin, 7);
    chk("p7_first_pmax", pmax, 7);
    chk("p7_first_err", err, 0);
    chk("p7_first_stall", stall, 0);
    run(WIN, 7, 7, 1);
    chk("p7_steady_count", count, 100);
    chk("p7_steady_pmax", pmax, 7);

    step(0, 0, ev, 1);
    step(1, 1, ev, 1);
    run(2 * WIN, 7, 8, 1);
    chk("alt_count", count, 93);
    chk("alt_pmin", pmin, 7);
    chk("alt_pmax", pmax, 8);
    chk("alt_err", err, 1);

    step(0, 0, ev, 1);
    step(1, 1, ev, 1);
    run(WIN, 10000, 10000, 1);
    chk("nocen_stall", stall, 1);
    chk("nocen_count", count, 0);
    chk("nocen_pmin", pmin, 255);
    chk("nocen_pmax", pmax, 0);
    chk("nocen_err", err, 1);

    step(0, 0, ev, 1);
    step(1, 1, ev, 1);
    run(WIN, 7, 7, 0);
    run(WIN, 7, 7, 2);
    chk("ack_on_latch_valid", valid, 1);
    chk("ack_on_latch_overrun", overrun, 0);
    run(WIN, 7, 7, 0);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_valid", valid, 1);
    chk("ovr_count", count, 100);

    step(0, 1, 1, 1);
    run(300, 7, 7, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("hold_count", count, 100);
    chk("hold_pmin", pmin, 7);
    chk("hold_valid", valid, 0);
    run(WIN + 50, 7, 7, 1);
    chk("resume_count", count, 100);

    run(200, 7, 7, 1);
    step(0, 1, 0, 0);
    check_reset("midreset");
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    n = 1;
    k = 0;
    while (valid !== 1'b1 && n < WIN + 20) begin
      k++;
      step(k % 7 == 0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    chk("sync_to_valid_edges", n, WIN + 1);
    chk("midreset_count", count, 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
